// File: rtl/seg7_pkg.sv
// Shared types and the fixed hex font for the seven-segment scan driver.
// Segment bit 0 is segment a, bit 6 is segment g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] data;
  } digit_t;

  localparam seg_t BLANK_SEG = 7'h00;

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, data: 4'h0};

  // 0-9, A, b, C, d, E, F
  localparam seg_t SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One spare address bit so out-of-range indices are representable and can be ignored.
  function automatic int addr_width(input int num_digits);
    return $clog2(num_digits) + 1;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Digit write bus of the scan driver: one digit per cycle, no handshake.
interface seg7_scan_mux_if
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  localparam int AddrW = addr_width(NUM_DIGITS);

  logic             wr_en;
  logic [AddrW-1:0] wr_addr;
  logic [3:0]       wr_data;
  logic             wr_dp;
  logic             wr_blank;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_dp,
    output wr_blank
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input wr_dp,
    input wr_blank
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  assign seg_o = SEG_FONT[hex_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver: per-digit storage, shadowed scan, PWM brightness,
// dead time at each slot start and optional output inversion for common-anode boards.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SLOT_LOG2   = 10,
  parameter int unsigned PWM_BITS    = 3,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  seg7_scan_mux_if.slave        wr,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  slot_tick
);

  localparam int AddrW = addr_width(NUM_DIGITS);
  localparam int IdxW  = $clog2(NUM_DIGITS);

  digit_t                digit_q [NUM_DIGITS];
  digit_t                digit_d [NUM_DIGITS];
  digit_t                shadow_q, shadow_d;
  logic [SLOT_LOG2-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  tick_q, tick_d;

  logic                  wrap;
  logic                  on_d;
  logic [PWM_BITS-1:0]   ph_d;
  seg_t                  font_seg;

  // Writes land regardless of ena; out-of-range indices are dropped.
  always_comb begin
    digit_d = digit_q;
    if (wr.wr_en && (wr.wr_addr < AddrW'(NUM_DIGITS))) begin
      digit_d[wr.wr_addr[IdxW-1:0]] = '{blank: wr.wr_blank, dp: wr.wr_dp, data: wr.wr_data};
    end
  end

  assign wrap = (cnt_q == {SLOT_LOG2{1'b1}});

  // The shadow copies the pre-write digit register, so a same-cycle write waits a visit.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    if (ena) begin
      cnt_d = cnt_q + SLOT_LOG2'(1);
      if (wrap) begin
        idx_d    = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        shadow_d = digit_q[idx_d];
        tick_d   = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .hex_i (shadow_d.data),
    .seg_o (font_seg)
  );

  // Outputs are computed from next state so the registered pins line up with cnt_q.
  assign ph_d = cnt_d[SLOT_LOG2-1 -: PWM_BITS];
  assign on_d = ena && (cnt_d >= SLOT_LOG2'(DEAD_CYCLES)) && (ph_d <= brightness);

  always_comb begin
    seg_d = BLANK_SEG;
    dp_d  = 1'b0;
    sel_d = '0;
    if (on_d) begin
      sel_d = NUM_DIGITS'(1) << idx_d;
      if (!shadow_d.blank) begin
        seg_d = font_seg;
        dp_d  = shadow_d.dp;
      end
    end
    seg_d = seg_d ^ {7{ACTIVE_LOW}};
    dp_d  = dp_d ^ ACTIVE_LOW;
    sel_d = sel_d ^ {NUM_DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q  <= '{default: DIGIT_RESET};
      shadow_q <= DIGIT_RESET;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= {7{ACTIVE_LOW}};
      dp_q     <= ACTIVE_LOW;
      sel_q    <= {NUM_DIGITS{ACTIVE_LOW}};
      tick_q   <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign dig_sel   = sel_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench: one active-high and one active-low instance of the scan driver.
module tb_seg7_scan_mux;

  logic       clk;
  logic       rst_n0, rst_n1;
  logic       ena0, ena1;
  logic [2:0] br0, br1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] sel0, sel1;
  logic       tk0, tk1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [6:0] exp_seg [4];

  seg7_scan_mux_if #(.NUM_DIGITS(4)) bus0 ();
  seg7_scan_mux_if #(.NUM_DIGITS(4)) bus1 ();

  seg7_scan_mux #(
    .NUM_DIGITS (4), .SLOT_LOG2 (10), .PWM_BITS (3), .DEAD_CYCLES (2), .ACTIVE_LOW (1'b0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n0), .ena (ena0), .wr (bus0.slave), .brightness (br0),
    .seg_out (seg0), .dp_out (dp0), .dig_sel (sel0), .slot_tick (tk0)
  );

  seg7_scan_mux #(
    .NUM_DIGITS (4), .SLOT_LOG2 (10), .PWM_BITS (3), .DEAD_CYCLES (2), .ACTIVE_LOW (1'b1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n1), .ena (ena1), .wr (bus1.slave), .brightness (br1),
    .seg_out (seg1), .dp_out (dp1), .dig_sel (sel1), .slot_tick (tk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr0(input logic [2:0] a, input logic [3:0] d, input logic dp, input logic bl);
    bus0.wr_en = 1'b1; bus0.wr_addr = a; bus0.wr_data = d; bus0.wr_dp = dp; bus0.wr_blank = bl;
    step(1);
    bus0.wr_en = 1'b0;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [3:0] d, input logic dp, input logic bl);
    bus1.wr_en = 1'b1; bus1.wr_addr = a; bus1.wr_data = d; bus1.wr_dp = dp; bus1.wr_blank = bl;
    step(1);
    bus1.wr_en = 1'b0;
  endtask

  // Leaves the bench on the first cycle of the next slot (cnt = 0).
  task automatic wait_tick(input bit which, input string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (((which ? tk1 : tk0) !== 1'b1) && (n < 2000));
    chk(tag, 32'(which ? tk1 : tk0), 32'd1);
  endtask

  initial begin
    exp_seg[0] = 7'h06; exp_seg[1] = 7'h5B; exp_seg[2] = 7'h4F; exp_seg[3] = 7'h66;
    rst_n0 = 1'b0; rst_n1 = 1'b0; ena0 = 1'b1; ena1 = 1'b1; br0 = 3'd7; br1 = 3'd7;
    bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0; bus0.wr_dp = 1'b0;
    bus0.wr_blank = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.wr_dp = 1'b0;
    bus1.wr_blank = 1'b0;
    step(3);

    chk("rst0_seg", 32'(seg0), 32'h00);
    chk("rst0_sel", 32'(sel0), 32'h0);
    chk("rst0_dp", 32'(dp0), 32'h0);
    chk("rst0_tick", 32'(tk0), 32'h0);
    chk("rst1_seg", 32'(seg1), 32'h7F);
    chk("rst1_sel", 32'(sel1), 32'hF);
    chk("rst1_dp", 32'(dp1), 32'h1);

    rst_n0 = 1'b1;
    #1 chk("rel0_sel", 32'(sel0), 32'h0);
    wr0(3'd0, 4'h1, 1'b0, 1'b0);
    wr0(3'd1, 4'h2, 1'b0, 1'b0);
    wr0(3'd2, 4'h3, 1'b0, 1'b0);
    wr0(3'd3, 4'h4, 1'b0, 1'b0);
    step(6);
    chk("blank_slot_sel", 32'(sel0), 32'h1);
    chk("blank_slot_seg", 32'(seg0), 32'h00);
    chk("blank_slot_dp", 32'(dp0), 32'h0);

    for (int s = 0; s < 4; s++) begin
      int d;
      d = (s + 1) % 4;
      wait_tick(1'b0, "scan_tick");
      chk("dead_cnt0_sel", 32'(sel0), 32'h0);
      chk("dead_cnt0_seg", 32'(seg0), 32'h00);
      step(1);
      chk("dead_cnt1_sel", 32'(sel0), 32'h0);
      chk("tick_one_cycle", 32'(tk0), 32'h0);
      step(1);
      chk("scan_cnt2_sel", 32'(sel0), 32'(4'b0001 << d));
      chk("scan_cnt2_seg", 32'(seg0), 32'(exp_seg[d]));
      step(998);
      chk("scan_cnt1000_sel", 32'(sel0), 32'(4'b0001 << d));
      chk("scan_cnt1000_seg", 32'(seg0), 32'(exp_seg[d]));
      chk("onehot", 32'($onehot0(sel0)), 32'd1);
    end

    br0 = 3'd0;
    wait_tick(1'b0, "pwm_tick");
    step(2);
    chk("pwm_cnt2_sel", 32'(sel0), 32'h2);
    chk("pwm_cnt2_seg", 32'(seg0), 32'h5B);
    step(125);
    chk("pwm_cnt127_sel", 32'(sel0), 32'h2);
    step(1);
    chk("pwm_cnt128_sel", 32'(sel0), 32'h0);
    chk("pwm_cnt128_seg", 32'(seg0), 32'h00);

    br0 = 3'd7;
    wait_tick(1'b0, "shadow_tick");
    step(10);
    chk("pre_write_seg", 32'(seg0), 32'h4F);
    wr0(3'd2, 4'hF, 1'b1, 1'b0);
    wr0(3'd5, 4'hE, 1'b0, 1'b0);
    step(8);
    chk("no_tear_seg", 32'(seg0), 32'h4F);
    chk("no_tear_dp", 32'(dp0), 32'h0);
    wait_tick(1'b0, "d3_tick");
    step(10);
    chk("d3_seg", 32'(seg0), 32'h66);
    wait_tick(1'b0, "d0_tick");
    step(10);
    chk("d0_seg", 32'(seg0), 32'h06);
    wait_tick(1'b0, "d1_tick");
    step(10);
    chk("oor_addr_seg", 32'(seg0), 32'h5B);
    wait_tick(1'b0, "d2_tick");
    step(10);
    chk("new_code_seg", 32'(seg0), 32'h71);
    chk("new_code_dp", 32'(dp0), 32'h1);
    chk("new_code_sel", 32'(sel0), 32'h4);

    step(290);
    chk("pre_hold_sel", 32'(sel0), 32'h4);
    ena0 = 1'b0;
    step(1);
    chk("hold_sel", 32'(sel0), 32'h0);
    chk("hold_seg", 32'(seg0), 32'h00);
    chk("hold_dp", 32'(dp0), 32'h0);
    step(99);
    chk("hold_end_sel", 32'(sel0), 32'h0);
    chk("hold_end_tick", 32'(tk0), 32'h0);
    ena0 = 1'b1;
    step(1);
    chk("resume_sel", 32'(sel0), 32'h4);
    chk("resume_seg", 32'(seg0), 32'h71);
    step(722);
    chk("resume_cnt1023_tick", 32'(tk0), 32'h0);
    chk("resume_cnt1023_sel", 32'(sel0), 32'h4);
    step(1);
    chk("resume_wrap_tick", 32'(tk0), 32'h1);
    chk("resume_wrap_sel", 32'(sel0), 32'h0);

    rst_n1 = 1'b1;
    wr1(3'd0, 4'h8, 1'b1, 1'b0);
    step(9);
    chk("al_blank_sel", 32'(sel1), 32'hE);
    chk("al_blank_seg", 32'(seg1), 32'h7F);
    chk("al_blank_dp", 32'(dp1), 32'h1);
    wait_tick(1'b1, "al_tick1");
    step(2);
    chk("al_d1_sel", 32'(sel1), 32'hD);
    chk("al_d1_seg", 32'(seg1), 32'h7F);
    wait_tick(1'b1, "al_tick2");
    wait_tick(1'b1, "al_tick3");
    wait_tick(1'b1, "al_tick0");
    step(2);
    chk("al_d0_sel", 32'(sel1), 32'hE);
    chk("al_d0_seg", 32'(seg1), 32'h00);
    chk("al_d0_dp", 32'(dp1), 32'h0);
    step(1);
    rst_n1 = 1'b0;
    #1;
    chk("al_async_seg", 32'(seg1), 32'h7F);
    chk("al_async_dp", 32'(dp1), 32'h1);
    chk("al_async_sel", 32'(sel1), 32'hF);
    chk("al_async_tick", 32'(tk1), 32'h0);
    rst_n1 = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
